// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart_top echo block: baud table, FSM states, parity.
package uart_pkg;

  localparam int CNT_W = 18;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  // Bit period in clocks, rounded to nearest; unused selects fall back to 115200.
  function automatic logic [CNT_W-1:0] baud_count(input logic [3:0] sel, input int unsigned clk_hz);
    int unsigned rate;
    case (sel)
      4'd0:    rate = 300;
      4'd1:    rate = 1200;
      4'd2:    rate = 2400;
      4'd3:    rate = 4800;
      4'd4:    rate = 9600;
      4'd5:    rate = 19200;
      4'd6:    rate = 38400;
      4'd7:    rate = 57600;
      4'd8:    rate = 115200;
      4'd9:    rate = 230400;
      4'd10:   rate = 460800;
      4'd11:   rate = 921600;
      default: rate = 115200;
    endcase
    return CNT_W'((clk_hz + rate / 2) / rate);
  endfunction

  function automatic logic parity_bit(input logic [7:0] data, input logic eight, input logic ohel);
    logic [7:0] m;
    m = data;
    if (!eight) m[7] = 1'b0;
    return (^m) ^ ohel;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable bit-period down-counter; o_tick marks the end of each period after a load.
module uart_bit_timer
  import uart_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_half,
  input  logic [CNT_W-1:0] i_n,
  output logic             o_tick
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_n;

  // The first interval may be a half period (start-bit centring); reloads are always full.
  always_ff @(posedge clk) begin
    if (reset)       r_cnt <= '1;
    else if (i_load) r_cnt <= (i_half ? (i_n >> 1) : i_n) - CNT_W'(1);
    else if (o_tick) r_cnt <= r_n - CNT_W'(1);
    else             r_cnt <= r_cnt - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (i_load) r_n <= i_n;
  end

  assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/uart_top.sv
// UART echo: receives frames on rx, checks them, retransmits each good byte on tx.
module uart_top
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       eight,
  input  logic       pen,
  input  logic       ohel,
  input  logic [3:0] baud,
  output logic       tx
);

  logic [CNT_W-1:0] w_baud_n;
  assign w_baud_n = baud_count(baud, CLK_HZ);

  // ---------------- RX: synchronizer and edge detect ----------------
  logic r_s1, r_s2, r_s3;
  logic w_rx_fall;
  always_ff @(posedge clk) begin
    if (reset) {r_s1, r_s2, r_s3} <= 3'b000;
    else       {r_s1, r_s2, r_s3} <= {rx, r_s1, r_s2};
  end
  assign w_rx_fall = r_s3 & ~r_s2;

  rx_state_t  r_rx_st, w_rx_nxt;
  logic       w_rx_load, w_rx_tick, w_rx_wr, w_rx_last;
  logic [2:0] r_rx_bcnt;
  logic [7:0] r_rx_data;
  logic       r_rx_eight, r_rx_pen, r_rx_ohel, r_rx_perr;

  uart_bit_timer u_rx_tmr (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_rx_load),
    .i_half (1'b1),
    .i_n    (w_baud_n),
    .o_tick (w_rx_tick)
  );

  assign w_rx_last = (r_rx_bcnt == (r_rx_eight ? 3'd7 : 3'd6));

  always_ff @(posedge clk) begin
    if (reset) r_rx_st <= RX_IDLE;
    else       r_rx_st <= w_rx_nxt;
  end

  always_comb begin
    w_rx_nxt  = r_rx_st;
    w_rx_load = 1'b0;
    w_rx_wr   = 1'b0;
    case (r_rx_st)
      RX_IDLE:   if (w_rx_fall) begin w_rx_load = 1'b1; w_rx_nxt = RX_START; end
      RX_START:  if (w_rx_tick) w_rx_nxt = r_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:   if (w_rx_tick && w_rx_last) w_rx_nxt = r_rx_pen ? RX_PARITY : RX_STOP;
      RX_PARITY: if (w_rx_tick) w_rx_nxt = RX_STOP;
      RX_STOP: begin
        if (w_rx_tick) begin
          w_rx_nxt = RX_IDLE;
          w_rx_wr  = r_s2 & ~(r_rx_pen & r_rx_perr);
        end
      end
      default:   w_rx_nxt = RX_IDLE;
    endcase
  end

  // Frame config is frozen at start detection so pin changes cannot corrupt a frame.
  always_ff @(posedge clk) begin
    if (w_rx_load) begin
      r_rx_data  <= '0;
      r_rx_bcnt  <= '0;
      r_rx_perr  <= 1'b0;
      r_rx_eight <= eight;
      r_rx_pen   <= pen;
      r_rx_ohel  <= ohel;
    end
    if (r_rx_st == RX_DATA && w_rx_tick) begin
      r_rx_data[r_rx_bcnt] <= r_s2;
      r_rx_bcnt            <= r_rx_bcnt + 3'd1;
    end
    if (r_rx_st == RX_PARITY && w_rx_tick)
      r_rx_perr <= r_s2 ^ parity_bit(r_rx_data, r_rx_eight, r_rx_ohel);
  end

  // ---------------- Echo buffer (one entry, newest wins) ----------------
  logic       r_buf_full;
  logic [7:0] r_buf_data;
  logic       w_tx_load;

  always_ff @(posedge clk) begin
    if (reset)          r_buf_full <= 1'b0;
    else if (w_rx_wr)   r_buf_full <= 1'b1;
    else if (w_tx_load) r_buf_full <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_rx_wr) r_buf_data <= r_rx_data;
  end

  // ---------------- TX ----------------
  tx_state_t  r_tx_st, w_tx_nxt;
  logic       w_tx_tick;
  logic [9:0] w_frame;
  logic [3:0] w_par_idx;
  logic [9:0] r_tx_sh;
  logic [3:0] r_tx_left;
  logic       r_tx;

  uart_bit_timer u_tx_tmr (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_tx_load),
    .i_half (1'b0),
    .i_n    (w_baud_n),
    .o_tick (w_tx_tick)
  );

  // Bits after the start bit, LSB first; trailing ones double as the stop bit.
  always_comb begin
    w_frame = '1;
    for (int i = 0; i < 8; i++)
      if (i < 7 || eight) w_frame[i] = r_buf_data[i];
    w_par_idx = eight ? 4'd8 : 4'd7;
    if (pen) w_frame[w_par_idx] = parity_bit(r_buf_data, eight, ohel);
  end

  always_ff @(posedge clk) begin
    if (reset) r_tx_st <= TX_IDLE;
    else       r_tx_st <= w_tx_nxt;
  end

  always_comb begin
    w_tx_nxt  = r_tx_st;
    w_tx_load = 1'b0;
    case (r_tx_st)
      TX_IDLE: if (r_buf_full) begin w_tx_load = 1'b1; w_tx_nxt = TX_SEND; end
      TX_SEND: if (w_tx_tick && r_tx_left == 4'd0) w_tx_nxt = TX_IDLE;
      default: w_tx_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)                                              r_tx <= 1'b1;
    else if (w_tx_load)                                     r_tx <= 1'b0;
    else if (r_tx_st == TX_SEND && w_tx_tick && r_tx_left != 4'd0) r_tx <= r_tx_sh[0];
  end

  always_ff @(posedge clk) begin
    if (w_tx_load) begin
      r_tx_sh   <= w_frame;
      r_tx_left <= 4'd8 + {3'b000, eight} + {3'b000, pen};
    end else if (r_tx_st == TX_SEND && w_tx_tick && r_tx_left != 4'd0) begin
      r_tx_sh   <= {1'b1, r_tx_sh[9:1]};
      r_tx_left <= r_tx_left - 4'd1;
    end
  end

  assign tx = r_tx;

endmodule

// File: tb/tb_uart_top.sv
// Randomized self-checking bench for uart_top: drives serial frames, decodes tx against a frame model.
module tb_uart_top;

  logic       clk, reset, rx, eight, pen, ohel, tx;
  logic [3:0] baud;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int cur_n = 54;
  int cur_nb = 9;

  localparam int NTAB [16] = '{166667, 41667, 20833, 10417, 5208, 2604, 1302, 868,
                               434, 217, 109, 54, 434, 434, 434, 434};

  typedef struct {
    int          t;
    logic [11:0] bits;
  } frm_t;
  frm_t mq[$];

  uart_top dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .eight (eight),
    .pen   (pen),
    .ohel  (ohel),
    .baud  (baud),
    .tx    (tx)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected line bits: start, data LSB first, parity (if enabled), stop; unused tail bits are 1.
  function automatic logic [11:0] model_frame(input logic [7:0] d, input bit e8, input bit pe, input bit odd);
    logic [11:0] f;
    int nd, ones, k;
    f = '1;
    nd = e8 ? 8 : 7;
    ones = 0;
    f[0] = 1'b0;
    k = 1;
    for (int i = 0; i < nd; i++) begin
      f[k] = d[i];
      ones += int'(d[i]);
      k++;
    end
    if (pe) begin
      f[k] = odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
      k++;
    end
    f[k] = 1'b1;
    return f;
  endfunction

  // Line monitor: decodes every frame on tx at mid-bit; a reset mid-frame aborts it.
  initial begin
    logic prev;
    frm_t f;
    int   n, nb;
    bit   abort;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b1;
      end else if (prev && tx === 1'b0) begin
        n = cur_n;
        nb = cur_nb;
        abort = 0;
        f.t = cyc;
        f.bits = '1;
        for (int k = 0; k < nb && !abort; k++) begin
          repeat ((k == 0) ? n / 2 : n) begin
            @(negedge clk);
            if (reset) abort = 1;
          end
          f.bits[k] = tx;
        end
        if (!abort) mq.push_back(f);
        prev = tx;
      end else begin
        prev = tx;
      end
    end
  end

  task automatic set_cfg(input bit e, input bit p, input bit o, input int b);
    @(negedge clk);
    eight = e;
    pen = p;
    ohel = o;
    baud = b[3:0];
    cur_n = NTAB[b];
    cur_nb = 2 + (e ? 8 : 7) + int'(p);
  endtask

  task automatic send_bits(input logic [11:0] f, input int nb, input int n, output int t0);
    @(negedge clk);
    t0 = cyc;
    for (int k = 0; k < nb; k++) begin
      rx = f[k];
      repeat (n) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic wait_frames(input int cnt, input int budget, output bit ok);
    int w;
    w = 0;
    while (mq.size() < cnt && w < budget) begin
      @(negedge clk);
      w++;
    end
    ok = (mq.size() >= cnt);
  endtask

  task automatic test_reset();
    bit bad;
    bad = 0;
    reset = 1'b1; rx = 1'b0; baud = 4'd11; eight = 1'b0; pen = 1'b0; ohel = 1'b0;
    cur_n = 54; cur_nb = 9;
    repeat (5) @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: tx=%b required 1", tx); end
    reset = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad = 1;
    end
    checks++;
    if (bad) begin failures++; $display("FAIL rx_low_idle: tx left 1 while rx held low, required steady 1"); end
    rx = 1'b1;
    repeat (200) @(negedge clk);
    checks++;
    if (mq.size() != 0) begin failures++; $display("FAIL rx_low_noframe: frames=%0d required 0", mq.size()); end
  endtask

  task automatic test_basic();
    logic [11:0] f;
    int t0, exp_t;
    bit ok;
    frm_t g;
    set_cfg(1, 0, 0, 11);
    mq.delete();
    f = model_frame(8'hA5, 1, 0, 0);
    send_bits(f, cur_nb, cur_n, t0);
    wait_frames(1, 4 * cur_nb * cur_n, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL a5_echo: frames=%0d required 1", mq.size());
    end else begin
      g = mq.pop_front();
      if (g.bits !== f) begin failures++; $display("FAIL a5_echo: bits=%h required %h", g.bits, f); end
      exp_t = t0 + 4 + cur_n / 2 + (cur_nb - 1) * cur_n;
      checks++;
      if (g.t < exp_t - 2 || g.t > exp_t + 2) begin
        failures++; $display("FAIL a5_latency: start at cycle %0d required %0d+-2", g.t, exp_t);
      end
    end
    repeat (cur_n) @(negedge clk);
  endtask

  task automatic test_parity();
    logic [11:0] f;
    int t0;
    bit ok;
    frm_t g;
    set_cfg(1, 1, 1, 11);
    mq.delete();
    f = model_frame(8'h03, 1, 1, 1);
    send_bits(f, cur_nb, cur_n, t0);
    wait_frames(1, 4 * cur_nb * cur_n, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL par_good_echo: frames=%0d required 1", mq.size());
    end else begin
      g = mq.pop_front();
      if (g.bits !== f) begin failures++; $display("FAIL par_good_echo: bits=%h required %h", g.bits, f); end
      checks++;
      if (g.bits[9] !== 1'b1) begin failures++; $display("FAIL par_bit_odd: parity=%b required 1", g.bits[9]); end
    end
    repeat (cur_n) @(negedge clk);
    mq.delete();
    f[9] = ~f[9];
    send_bits(f, cur_nb, cur_n, t0);
    repeat ((cur_nb + 3) * cur_n) @(negedge clk);
    checks++;
    if (mq.size() != 0) begin failures++; $display("FAIL par_bad_drop: frames=%0d required 0", mq.size()); end
  endtask

  task automatic test_seven();
    logic [11:0] f;
    int t0;
    bit ok;
    frm_t g;
    set_cfg(0, 1, 0, 8);
    mq.delete();
    f = model_frame(8'h41, 0, 1, 0);
    send_bits(f, cur_nb, cur_n, t0);
    wait_frames(1, 4 * cur_nb * cur_n, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL seven_echo: frames=%0d required 1", mq.size());
    end else begin
      g = mq.pop_front();
      if (g.bits !== f) begin failures++; $display("FAIL seven_echo: bits=%h required %h", g.bits, f); end
    end
    repeat (cur_n) @(negedge clk);
  endtask

  task automatic test_errors();
    logic [11:0] f;
    int t0;
    set_cfg(1, 0, 0, 11);
    mq.delete();
    f = model_frame(8'h5C, 1, 0, 0);
    f[9] = 1'b0;
    send_bits(f, cur_nb, cur_n, t0);
    repeat ((cur_nb + 3) * cur_n) @(negedge clk);
    checks++;
    if (mq.size() != 0) begin failures++; $display("FAIL stop_err_drop: frames=%0d required 0", mq.size()); end
    @(negedge clk);
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat ((cur_nb + 3) * cur_n) @(negedge clk);
    checks++;
    if (mq.size() != 0) begin failures++; $display("FAIL glitch_drop: frames=%0d required 0", mq.size()); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d [3];
    logic [11:0] f;
    int t0, w;
    bit ok, bad;
    frm_t g;
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
    set_cfg(1, 0, 0, 11);
    mq.delete();
    for (int i = 0; i < 3; i++) send_bits(model_frame(d[i], 1, 0, 0), cur_nb, cur_n, t0);
    wait_frames(3, 4 * cur_nb * cur_n, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL b2b_count: frames=%0d required 3", mq.size()); end
    for (int i = 0; i < 3; i++) begin
      if (mq.size() > 0) begin
        g = mq.pop_front();
        f = model_frame(d[i], 1, 0, 0);
        checks++;
        if (g.bits !== f) begin failures++; $display("FAIL b2b_frame%0d: bits=%h required %h", i, g.bits, f); end
      end
    end
    repeat (cur_n) @(negedge clk);
    // Reset while an echo is on the wire.
    mq.delete();
    send_bits(model_frame(8'h5A, 1, 0, 0), cur_nb, cur_n, t0);
    w = 0;
    while (tx !== 1'b0 && w < 2000) begin @(negedge clk); w++; end
    checks++;
    if (tx !== 1'b0) begin failures++; $display("FAIL midreset_echo_start: tx=%b required 0", tx); end
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin failures++; $display("FAIL midreset_tx: tx=%b required 1", tx); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (3 * cur_nb * cur_n) begin
      @(negedge clk);
      if (tx !== 1'b1) bad = 1;
    end
    checks++;
    if (bad || mq.size() != 0) begin
      failures++; $display("FAIL midreset_quiet: frames=%0d low_seen=%0d required 0 0", mq.size(), bad);
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic [11:0] f, fe;
    bit e, p, o, ok;
    int b, err, t0, nd;
    frm_t g;
    for (int it = 0; it < 8; it++) begin
      e = 1'($urandom_range(0, 1));
      p = 1'($urandom_range(0, 1));
      o = 1'($urandom_range(0, 1));
      b = $urandom_range(10, 11);
      d = 8'($urandom);
      err = $urandom_range(0, 3);
      set_cfg(e, p, o, b);
      mq.delete();
      nd = e ? 8 : 7;
      fe = model_frame(d, e, p, o);
      f = fe;
      if (err == 1 && p) f[1 + nd] = ~f[1 + nd];
      else if (err == 2) f[cur_nb - 1] = 1'b0;
      else err = 0;
      send_bits(f, cur_nb, cur_n, t0);
      if (err == 0) begin
        wait_frames(1, 4 * cur_nb * cur_n, ok);
        checks++;
        if (!ok) begin
          failures++; $display("FAIL rand%0d_echo: frames=%0d required 1", it, mq.size());
        end else begin
          g = mq.pop_front();
          if (g.bits !== fe) begin
            failures++; $display("FAIL rand%0d_echo: d=%h cfg=%b%b%b bits=%h required %h", it, d, e, p, o, g.bits, fe);
          end
        end
        repeat (cur_n) @(negedge clk);
      end else begin
        repeat ((cur_nb + 3) * cur_n) @(negedge clk);
        checks++;
        if (mq.size() != 0) begin failures++; $display("FAIL rand%0d_drop: frames=%0d required 0", it, mq.size()); end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    rx = 1'b0;
    eight = 1'b0; pen = 1'b0; ohel = 1'b0; baud = 4'd11;
    test_reset();
    test_basic();
    test_parity();
    test_seven();
    test_errors();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_900_000;
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "watchdog");
  end

endmodule
